// File: rtl/axis_axi_wr_master.sv
// AXI-Stream to AXI4 write master: drains cmd_len stream words to memory as INCR bursts
// of at most MAX_BURST_LEN beats that never cross a 4 KB boundary, one burst in flight.
module axis_axi_wr_master #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 16,
    parameter int STRB_WIDTH    = DATA_WIDTH / 8,
    parameter int ID_WIDTH      = 8,
    parameter int AWID          = 0,
    parameter int LEN_WIDTH     = 16,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,

    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,

    output logic                  busy,
    output logic                  done,
    output logic                  error,

    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready
);

    localparam int SIZE = $clog2(STRB_WIDTH);
    // Wide enough for the word count plus one and for the 4 KB distance (4096).
    localparam int CW   = (LEN_WIDTH + 1 > 14) ? LEN_WIDTH + 1 : 14;

    typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  remain_q, remain_d;
    logic [8:0]            beat_cnt_q, beat_cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  cmd_ready_q, cmd_ready_d;

    logic [12:0]           bound_bytes;
    logic [CW-1:0]         bound;
    logic [CW-1:0]         beats;
    logic [LEN_WIDTH-1:0]  remain_next;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic                  last_beat;
    logic                  unused_bid;

    assign unused_bid  = ^m_axi_bid;
    assign bound_bytes = 13'h1000 - {1'b0, addr_q[11:0]};

    // Burst size is derived from the live address/remaining count, which only change
    // on the B handshake, so it stays constant for the whole burst.
    always_comb begin
        bound = CW'(bound_bytes >> SIZE);
        beats = CW'(remain_q);
        if (beats > CW'(MAX_BURST_LEN)) beats = CW'(MAX_BURST_LEN);
        if (beats > bound) beats = bound;
    end

    assign remain_next = remain_q - LEN_WIDTH'(beats);
    assign addr_next   = addr_q + (ADDR_WIDTH'(beats) << SIZE);
    assign last_beat   = (CW'(beat_cnt_q) == beats - CW'(1));

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        beat_cnt_d = beat_cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d   = cmd_addr;
                    remain_d = cmd_len;
                    error_d  = 1'b0;
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = StAddr;
                    end
                end
            end
            StAddr: begin
                if (m_axi_awready) begin
                    beat_cnt_d = '0;
                    state_d    = StData;
                end
            end
            StData: begin
                if (s_axis_tvalid && m_axi_wready) begin
                    beat_cnt_d = beat_cnt_q + 9'd1;
                    if (last_beat) state_d = StResp;
                end
            end
            StResp: begin
                if (m_axi_bvalid) begin
                    error_d  = error_q | (m_axi_bresp != 2'b00);
                    addr_d   = addr_next;
                    remain_d = remain_next;
                    if (remain_next == '0) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        state_d = StAddr;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // Ready drops during the done cycle so it returns the cycle after done.
        cmd_ready_d = (state_d == StIdle) && !done_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q     <= addr_d;
        remain_q   <= remain_d;
        beat_cnt_q <= beat_cnt_d;
    end

    assign cmd_ready     = cmd_ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;

    assign m_axi_awid    = ID_WIDTH'(AWID);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = 8'(beats - CW'(1));
    assign m_axi_awsize  = 3'(SIZE);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = (state_q == StAddr);

    assign m_axi_wdata   = s_axis_tdata;
    assign m_axi_wstrb   = {STRB_WIDTH{1'b1}};
    assign m_axi_wlast   = last_beat;
    assign m_axi_wvalid  = (state_q == StData) && s_axis_tvalid;
    assign s_axis_tready = (state_q == StData) && m_axi_wready;
    assign m_axi_bready  = (state_q == StResp);

endmodule

// File: tb/tb_axis_axi_wr_master.sv
// Bench for axis_axi_wr_master: AXI slave/RAM model plus AW/W scoreboards, one task per scenario.
module tb_axis_axi_wr_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cmd_addr = '0;
    logic [15:0] cmd_len = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        busy, done, error;
    logic [7:0]  m_axi_awid;
    logic [15:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awlock;
    logic [3:0]  m_axi_awcache;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_awvalid;
    logic        m_axi_awready = 1'b0;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_wvalid;
    logic        m_axi_wready = 1'b0;
    logic [7:0]  m_axi_bid = '0;
    logic [1:0]  m_axi_bresp = '0;
    logic        m_axi_bvalid = 1'b0;
    logic        m_axi_bready;

    always #5 clk = ~clk;

    axis_axi_wr_master dut (
        .clk(clk), .rst(rst),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .busy(busy), .done(done), .error(error),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache),
        .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready)
    );

    int          checks = 0;
    int          failures = 0;
    logic [31:0] mem [0:16383];
    logic [31:0] st_q[$];
    logic [31:0] exp_w[$];
    logic [23:0] exp_aw[$];
    bit          rnd = 0;
    int          err_burst = -1;
    int          burst_idx = 0;
    int          aw_count = 0, w_count = 0, done_count = 0;
    bit          first_aw;
    bit          last_err;
    int          done_wait;

    // Slave + stream source: drive on the falling edge, sample 1 ns later; the sampled
    // values are exactly what the next rising edge will see.
    always @(negedge clk) begin : slave
        logic [23:0] e;
        static bit          aw_open = 0, aw_hold = 0, b_pending = 0, t_hs = 0, b_hs = 0;
        static logic [15:0] cur_addr = '0, hold_addr = '0;
        static logic [7:0]  cur_len = '0, hold_len = '0;
        static int          beat = 0;
        if (t_hs) begin
            void'(st_q.pop_front());
            s_axis_tvalid = 1'b0;
            t_hs = 0;
        end
        if (b_hs) begin
            m_axi_bvalid = 1'b0;
            b_hs = 0;
        end
        m_axi_awready = rnd ? ($urandom_range(0, 2) == 0) : 1'b1;
        m_axi_wready  = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (!m_axi_bvalid && b_pending && (!rnd || $urandom_range(0, 2) == 0)) begin
            m_axi_bvalid = 1'b1;
            m_axi_bresp  = (burst_idx == err_burst) ? 2'b10 : 2'b00;
        end
        if (!s_axis_tvalid && st_q.size() > 0 && (!rnd || $urandom_range(0, 2) != 0)) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = st_q[0];
        end
        #1;
        if (rst) begin
            st_q.delete(); exp_w.delete(); exp_aw.delete();
            aw_open = 0; aw_hold = 0; b_pending = 0; t_hs = 0; b_hs = 0;
            s_axis_tvalid = 1'b0; m_axi_bvalid = 1'b0; burst_idx = 0;
        end else begin
            if (m_axi_awvalid) begin
                if (aw_hold) begin
                    checks++;
                    if (m_axi_awaddr !== hold_addr || m_axi_awlen !== hold_len) begin
                        failures++;
                        $display("FAIL aw_stable got=%h/%h exp=%h/%h", m_axi_awaddr,
                                 m_axi_awlen, hold_addr, hold_len);
                    end
                end
                if (m_axi_awready) begin
                    checks++;
                    if (exp_aw.size() == 0) begin
                        failures++;
                        $display("FAIL aw_unexpected got=%h/%h", m_axi_awaddr, m_axi_awlen);
                    end else begin
                        e = exp_aw.pop_front();
                        if ({m_axi_awaddr, m_axi_awlen} !== e) begin
                            failures++;
                            $display("FAIL aw_fields got=%h exp=%h",
                                     {m_axi_awaddr, m_axi_awlen}, e);
                        end
                    end
                    checks++;
                    if ({m_axi_awid, m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache,
                         m_axi_awprot} !== {8'h00, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000}) begin
                        failures++;
                        $display("FAIL aw_const got=%h/%h/%h/%h/%h/%h", m_axi_awid,
                                 m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache,
                                 m_axi_awprot);
                    end
                    aw_open = 1; aw_hold = 0; beat = 0; aw_count++;
                    cur_addr = m_axi_awaddr; cur_len = m_axi_awlen;
                end else begin
                    aw_hold = 1; hold_addr = m_axi_awaddr; hold_len = m_axi_awlen;
                end
            end else begin
                aw_hold = 0;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                checks++;
                if (!aw_open) begin
                    failures++;
                    $display("FAIL w_before_aw got=%h", m_axi_wdata);
                end
                checks++;
                if (exp_w.size() == 0) begin
                    failures++;
                    $display("FAIL w_unexpected got=%h", m_axi_wdata);
                end else begin
                    e = 24'(0);
                    if ({m_axi_wdata, m_axi_wstrb} !== {exp_w[0], 4'hF}) begin
                        failures++;
                        $display("FAIL w_data got=%h/%h exp=%h/f", m_axi_wdata, m_axi_wstrb,
                                 exp_w[0]);
                    end
                    void'(exp_w.pop_front());
                end
                checks++;
                if (m_axi_wlast !== (beat == int'(cur_len))) begin
                    failures++;
                    $display("FAIL wlast got=%b exp=%b beat=%0d", m_axi_wlast,
                             (beat == int'(cur_len)), beat);
                end
                mem[((int'(cur_addr) >> 2) + beat) & 16383] = m_axi_wdata;
                beat++; w_count++;
                if (m_axi_wlast) begin
                    aw_open = 0; b_pending = 1;
                end
            end
            if (busy) begin
                checks++;
                if (cmd_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL cmd_ready_busy got=%b exp=0", cmd_ready);
                end
            end
            if (s_axis_tvalid && s_axis_tready) t_hs = 1;
            if (m_axi_bvalid && m_axi_bready) begin
                b_hs = 1; b_pending = 0; burst_idx++;
            end
            if (done) begin
                done_count++; burst_idx = 0;
            end
        end
    end

    task automatic recover();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_xfer(input int addr, input int len, input logic [31:0] seed);
        int a, r, b, bnd;
        bit got;
        a = addr; r = len;
        while (r > 0) begin
            b = (r > 16) ? 16 : r;
            bnd = (4096 - (a % 4096)) / 4;
            if (b > bnd) b = bnd;
            exp_aw.push_back({16'(a), 8'(b - 1)});
            a = (a + b * 4) % 65536;
            r -= b;
        end
        for (int i = 0; i < len; i++) begin
            st_q.push_back(seed + 32'(i));
            exp_w.push_back(seed + 32'(i));
        end
        @(negedge clk);
        cmd_addr = 16'(addr); cmd_len = 16'(len); cmd_valid = 1'b1;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            #2;
            if (cmd_ready) got = 1;
            else @(negedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        #2;
        first_aw = m_axi_awvalid;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL cmd_accept_timeout got=0 exp=1");
        end
    endtask

    task automatic finish_xfer();
        bit got = 0;
        done_wait = 0;
        for (int i = 0; i < 5000 && !got; i++) begin
            if (done) begin
                got = 1; last_err = error; done_wait = i;
            end else begin
                @(negedge clk); #2;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL done_timeout got=0 exp=1");
            recover();
            return;
        end
        @(negedge clk); #2;
        checks++;
        if ({done, cmd_ready} !== 2'b01) begin
            failures++;
            $display("FAIL done_pulse_ready got=%b%b exp=01", done, cmd_ready);
        end
        checks++;
        if (exp_aw.size() != 0 || exp_w.size() != 0) begin
            failures++;
            $display("FAIL leftover aw=%0d w=%0d exp=0/0", exp_aw.size(), exp_w.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if ({cmd_ready, busy, done, error, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
             s_axis_tready} !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=00000000", {cmd_ready, busy, done, error,
                     m_axi_awvalid, m_axi_wvalid, m_axi_bready, s_axis_tready});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #2;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready);
        end
    endtask

    task automatic test_single();
        int a0 = aw_count, w0 = w_count, d0 = done_count;
        start_xfer(16'h0010, 1, 32'hA5A5A5A5);
        finish_xfer();
        checks++;
        if (first_aw !== 1'b1) begin
            failures++;
            $display("FAIL single_aw_latency got=%b exp=1", first_aw);
        end
        checks++;
        if (aw_count - a0 != 1 || w_count - w0 != 1 || done_count - d0 != 1 || last_err) begin
            failures++;
            $display("FAIL single_counts got=aw%0d w%0d d%0d e%0b exp=aw1 w1 d1 e0",
                     aw_count - a0, w_count - w0, done_count - d0, last_err);
        end
        checks++;
        if (mem[4] !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL single_readback got=%h exp=a5a5a5a5", mem[4]);
        end
    endtask

    task automatic test_multi_burst();
        int a0 = aw_count, d0 = done_count;
        start_xfer(16'h0000, 40, 32'h1000_0000);
        finish_xfer();
        checks++;
        if (aw_count - a0 != 3 || done_count - d0 != 1 || last_err) begin
            failures++;
            $display("FAIL multi_counts got=aw%0d d%0d e%0b exp=aw3 d1 e0", aw_count - a0,
                     done_count - d0, last_err);
        end
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (mem[i] !== 32'h1000_0000 + 32'(i)) begin
                failures++;
                $display("FAIL multi_ram[%0d] got=%h exp=%h", i, mem[i], 32'h1000_0000 + i);
            end
        end
    endtask

    task automatic test_4k_split();
        int a0 = aw_count;
        start_xfer(16'h0FF0, 8, 32'h2000_0000);
        finish_xfer();
        checks++;
        if (aw_count - a0 != 2) begin
            failures++;
            $display("FAIL split_aw_count got=%0d exp=2", aw_count - a0);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (mem[16'h03FC + i] !== 32'h2000_0000 + 32'(i)) begin
                failures++;
                $display("FAIL split_ram[%0d] got=%h exp=%h", i, mem[16'h03FC + i],
                         32'h2000_0000 + i);
            end
        end
    endtask

    task automatic test_backpressure();
        int w0 = w_count, d0 = done_count;
        rnd = 1;
        start_xfer(16'h0400, 33, 32'h3000_0000);
        finish_xfer();
        rnd = 0;
        checks++;
        if (w_count - w0 != 33 || done_count - d0 != 1) begin
            failures++;
            $display("FAIL bp_counts got=w%0d d%0d exp=w33 d1", w_count - w0, done_count - d0);
        end
        for (int i = 0; i < 33; i++) begin
            checks++;
            if (mem[16'h0100 + i] !== 32'h3000_0000 + 32'(i)) begin
                failures++;
                $display("FAIL bp_ram[%0d] got=%h exp=%h", i, mem[16'h0100 + i],
                         32'h3000_0000 + i);
            end
        end
    endtask

    task automatic test_error_zero();
        int a0 = aw_count, d0;
        err_burst = 1;
        start_xfer(16'h0800, 40, 32'h4000_0000);
        finish_xfer();
        err_burst = -1;
        checks++;
        if (aw_count - a0 != 3 || last_err !== 1'b1) begin
            failures++;
            $display("FAIL err_xfer got=aw%0d e%0b exp=aw3 e1", aw_count - a0, last_err);
        end
        checks++;
        if (mem[16'h0200 + 39] !== 32'h4000_0000 + 32'd39) begin
            failures++;
            $display("FAIL err_ram_last got=%h exp=%h", mem[16'h0200 + 39], 32'h4000_0027);
        end
        a0 = aw_count; d0 = done_count;
        start_xfer(16'h0900, 0, 32'h0);
        finish_xfer();
        checks++;
        if (done_wait != 0 || aw_count != a0 || last_err !== 1'b0 || done_count - d0 != 1) begin
            failures++;
            $display("FAIL zero_len got=wait%0d aw%0d e%0b d%0d exp=wait0 aw0 e0 d1",
                     done_wait, aw_count - a0, last_err, done_count - d0);
        end
    endtask

    task automatic test_reset_mid();
        int w0 = w_count, d0, a0;
        bit got = 0;
        start_xfer(16'h0A00, 16, 32'h5000_0000);
        for (int i = 0; i < 200 && !got; i++) begin
            if (w_count - w0 >= 5) got = 1;
            else begin
                @(negedge clk); #2;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL mid_wait_timeout got=%0d exp=5", w_count - w0);
        end
        d0 = done_count;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #2;
        checks++;
        if ({cmd_ready, busy, done, error, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
             s_axis_tready} !== 8'h00 || done_count != d0) begin
            failures++;
            $display("FAIL mid_reset got=%b dones=%0d exp=00000000 dones=0", {cmd_ready, busy,
                     done, error, m_axi_awvalid, m_axi_wvalid, m_axi_bready, s_axis_tready},
                     done_count - d0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #2;
        checks++;
        if (cmd_ready !== 1'b1 || done_count != d0) begin
            failures++;
            $display("FAIL mid_after_reset got=%b/%0d exp=1/0", cmd_ready, done_count - d0);
        end
        a0 = aw_count; d0 = done_count;
        start_xfer(16'h0A00, 4, 32'h6000_0000);
        finish_xfer();
        checks++;
        if (aw_count - a0 != 1 || done_count - d0 != 1 || last_err) begin
            failures++;
            $display("FAIL mid_new_cmd got=aw%0d d%0d e%0b exp=aw1 d1 e0", aw_count - a0,
                     done_count - d0, last_err);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[16'h0280 + i] !== 32'h6000_0000 + 32'(i)) begin
                failures++;
                $display("FAIL mid_ram[%0d] got=%h exp=%h", i, mem[16'h0280 + i],
                         32'h6000_0000 + i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi_burst();
        test_4k_split();
        test_backpressure();
        test_error_zero();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axis_axi_wr_master.md
Name: axis_axi_wr_master

Overview:
- AXI-Stream to AXI4 write master. Sits directly upstream of the AXI4 RAM slave and drives its AW/W/B channels.
- Accepts a command (base byte address, word count) and drains that many stream beats into memory.
- Splits each transfer into INCR bursts, up to MAX_BURST_LEN beats each, that never cross a 4 KB boundary.
- Reports completion and any error response. One burst is outstanding at a time.

Parameters:
- DATA_WIDTH, 32, AXI and stream data width in bits.
- ADDR_WIDTH, 16, AXI byte address width.
- STRB_WIDTH, DATA_WIDTH/8, wstrb width.
- ID_WIDTH, 8, AXI ID width.
- AWID, 0, constant ID driven on awid.
- LEN_WIDTH, 16, width of the command word count.
- MAX_BURST_LEN, 16, maximum beats per burst, range 1..256.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_addr  in  ADDR_WIDTH  start byte address; must be STRB_WIDTH-aligned
- cmd_len  in  LEN_WIDTH  number of data words to write
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when high with cmd_valid
- s_axis_tdata  in  DATA_WIDTH  stream data
- s_axis_tvalid  in  1  stream valid
- s_axis_tready  out  1  stream ready
- busy  out  1  high from command accept until done
- done  out  1  one-cycle pulse at transfer end
- error  out  1  sticky for the transfer; valid when done=1
- m_axi_awid  out  ID_WIDTH  =AWID
- m_axi_awaddr  out  ADDR_WIDTH  burst address
- m_axi_awlen  out  8  beats-1
- m_axi_awsize  out  3  $clog2(STRB_WIDTH)
- m_axi_awburst  out  2  2'b01 (INCR)
- m_axi_awlock  out  1  0
- m_axi_awcache  out  4  4'b0011
- m_axi_awprot  out  3  3'b000
- m_axi_awvalid  out  1  address valid
- m_axi_awready  in  1  address ready
- m_axi_wdata  out  DATA_WIDTH  =s_axis_tdata
- m_axi_wstrb  out  STRB_WIDTH  all ones
- m_axi_wlast  out  1  last beat of burst
- m_axi_wvalid  out  1  write valid
- m_axi_wready  in  1  write ready
- m_axi_bid  in  ID_WIDTH  ignored
- m_axi_bresp  in  2  write response
- m_axi_bvalid  in  1  response valid
- m_axi_bready  out  1  response ready

Behaviour:
- **Reset values:** state=IDLE, cmd_ready=0, busy=0, done=0, error=0, awvalid=0, wvalid=0, bready=0, s_axis_tready=0. Address and counter registers are don't-care. Reset mid-burst abandons the transfer immediately with no done pulse; the downstream slave must be reset with it.
- **States:** IDLE, ADDR, DATA, RESP.
- **IDLE:**
  - cmd_ready=1 (registered; asserts the cycle after reset deasserts).
  - On cmd_valid&&cmd_ready, latch addr_reg=cmd_addr and remain_reg=cmd_len, then clear error.
  - If cmd_len==0: done pulses the next cycle and the state stays IDLE.
  - Otherwise: busy=1, cmd_ready=0, go to ADDR.
- **ADDR entry:** compute beats = min(remain_reg, MAX_BURST_LEN, (4096 - addr_reg[11:0]) >> $clog2(STRB_WIDTH)). Use LEN_WIDTH+1-bit arithmetic; the result is always ≥1.
- **ADDR:**
  - awaddr=addr_reg, awlen=beats-1, awvalid=1.
  - awvalid and all AW fields stay stable until awready.
  - On handshake: awvalid=0 the next cycle, beat_cnt=0, go to DATA.
- **DATA:**
  - Pass-through, combinational: wvalid=s_axis_tvalid, s_axis_tready=m_axi_wready, wdata=tdata, wlast=(beat_cnt==beats-1).
  - Outside DATA, s_axis_tready=0 and wvalid=0.
  - Each wvalid&&wready increments beat_cnt.
  - On the beat with wlast: go to RESP.
- **RESP:**
  - bready=1.
  - On bvalid: error |= (bresp!=2'b00); addr_reg += beats*STRB_WIDTH (wraps modulo 2^ADDR_WIDTH); remain_reg -= beats.
  - If the new remain is 0: done=1 for one cycle, busy=0, go to IDLE; cmd_ready returns 1 the cycle after done.
  - Else: go to ADDR.
- **Latency:** the first awvalid appears 1 cycle after the command handshake. With zero-wait slave responses there is one idle cycle between bursts (RESP→ADDR).
- **Error handling:** error responses do not abort the transfer; all words are still written.
- **Ordering:** AW always precedes W; W beats are never issued before the AW handshake.
- **Other events:** a command presented while busy is held off (cmd_ready=0). Stream data outside DATA is not consumed.

Test Plan:
- Single word: cmd_addr=0x0010, cmd_len=1, tdata=0xA5A5A5A5 → one AW with awaddr=0x0010, awlen=0; one W with wlast=1; done once; error=0; readback 0xA5A5A5A5 from RAM.
- Multi-burst: addr 0x0000, len 40, MAX_BURST_LEN=16 → three AWs with awlen 15,15,7 at 0x0000, 0x0040, 0x0080; wlast on beats 16, 32, 40; RAM holds the incrementing pattern.
- 4 KB split: addr 0x0FF0, len 8, 32-bit → AW at 0x0FF0 len 3, then at 0x1000 len 3; no burst crosses 0x1000.
- Backpressure: random tvalid gaps and random wready/awready/bvalid delays, len 33 → data order preserved; AW fields stable while awvalid; exactly 33 W handshakes; one done.
- Error and zero length: slave returns bresp=2'b10 on burst 2 of 3 → all bursts complete, done with error=1. Then cmd_len=0 → done the next cycle, no AXI activity, error=0.
- Reset mid-DATA: assert rst after beat 5 of 16 → all outputs reach their reset values the next cycle with no done pulse. A new command after reset completes normally.
